// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants, FSM encoding and sizing helper.
// Imported by the fetch top, its buffer and nothing else.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic int unsigned cnt_w(
    int unsigned depth
  );
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch stage and imem.
// master = fetch side, slave = memory side.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO buffering {instr, pc_plus4} records.
// Flush empties it in one cycle; DEPTH must be a power of 2.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic          wen;
  logic          ren;

  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign wen   = push && (!full || pop) && !flush;
  assign ren   = pop && !empty && !flush;
  assign dout  = mem[rd];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (wen) wr <= wr + 1'b1;
      if (ren) rd <= rd + 1'b1;
      unique case ({wen, ren})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wen) mem[wr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: PC, single-outstanding imem reads, redirect/flush, buffer.
// FETCH_ALIGN_CHK_EN adds a sticky align_err for misaligned targets.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  instr_fetch_if.master     imem,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_plus4
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic              align_err
`endif
);

  localparam int unsigned CW = cnt_w(FIFO_DEPTH);
  localparam int unsigned DW = 32 + ADDR_W;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] target;
  logic              req;
  logic              busy;
  logic              drop;
  logic              ret;
  logic              push;
  logic              pop;
  logic              issue;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;
  logic [DW-1:0]     head;
  logic [DW-1:0]     din;

  assign target = {branch_target[ADDR_W-1:2], 2'b00};
  assign busy   = state != IDLE;
  assign drop   = state == DRAIN;
  // a return with nothing outstanding is stale and ignored
  assign ret    = imem.imem_valid && busy;
  assign pop    = !empty && !stall && !branch_taken;
  assign push   = ret && !drop && !branch_taken
                && (!full || pop);
  assign issue  = !busy && !branch_taken
                && (count < CW'(FIFO_DEPTH));
  assign din    = {imem.imem_rdata, req_addr + INC};

  assign imem.imem_req  = req;
  assign imem.imem_addr = req_addr;

  assign instr_valid = !empty;
  assign instr    = empty ? NOP_INSTR : head[DW-1:ADDR_W];
  assign pc_plus4 = empty ? '0 : head[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req      <= 1'b0;
      req_addr <= '0;
    end else begin
      req <= 1'b0;
      if (branch_taken) pc <= target;
      unique case (state)
        IDLE: begin
          if (issue) begin
            req      <= 1'b1;
            req_addr <= pc;
            pc       <= pc + INC;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_valid) state <= IDLE;
          else if (branch_taken) state <= DRAIN;
        end
        DRAIN: begin
          if (imem.imem_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  instr_fetch_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .din   (din),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

`ifdef FETCH_ALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      align_err <= 1'b0;
    end else if (branch_taken
                 && branch_target[1:0] != 2'b00) begin
      align_err <= 1'b1;
    end
  end
`else
  logic [1:0] unused_lo;
  assign unused_lo = branch_target[1:0];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: latency-programmable imem model, scoreboard
// of expected {instr, pc_plus4} and directed redirect/stall/reset cases.
module tb_instr_fetch;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [AW-1:0] pc_plus4;
`ifdef FETCH_ALIGN_CHK_EN
  logic          align_err;
`endif

  instr_fetch_if #(.ADDR_W(AW)) bus ();

  instr_fetch #(
    .ADDR_W     (AW),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc_plus4      (pc_plus4)
`ifdef FETCH_ALIGN_CHK_EN
    ,
    .align_err     (align_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        err;
  } vec_t;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  int          mem_lat = 1;
  int          cd = 0;
  int          nreq = 0;
  int          cyc = 0;
  int          inj_cyc = -1;
  bit          mem_kill = 1'b1;
  bit          mon_en = 1'b0;
  logic        req_n = 1'b0;
  logic [31:0] addr_n = '0;
  logic [31:0] pa = '0;

  function automatic logic [31:0] word(logic [31:0] a);
    return 32'h2008_0005 ^ {a[15:2], 18'h0};
  endfunction

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // memory: sample the request on the falling edge, answer after
  // mem_lat rising edges; expectations are queued at acceptance
  always @(negedge clk) begin
    req_n  = bus.imem_req;
    addr_n = bus.imem_addr;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    bus.imem_valid = 1'b0;
    if (mem_kill) begin
      cd = 0;
    end else if (req_n) begin
      pa = addr_n;
      cd = mem_lat;
      nreq++;
      q.push_back('{word(addr_n), addr_n + 32'd4});
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.imem_valid = 1'b1;
        bus.imem_rdata = word(pa);
      end
    end
    if (cyc == inj_cyc) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (instr_valid && !stall && !branch_taken) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL pop_unexpected: got %h expected none",
                   instr);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("instr", instr, e.i);
          chk("pc_plus4", pc_plus4, e.p);
        end
      end else if (!instr_valid) begin
        chk("nop_instr", instr, 32'h0);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    mem_kill = 1'b1;
    stall = 1'b0;
    step(n);
    q.delete();
    reset = 1'b1;
    mem_kill = 1'b0;
  endtask

  task automatic do_branch(logic [31:0] t);
    branch_taken = 1'b1;
    branch_target = t;
    step(1);
    q.delete();
    branch_taken = 1'b0;
  endtask

  task automatic expect_req(string n, logic [31:0] exp);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.imem_req;
    end
    if (got) begin
      chk(n, bus.imem_addr, exp);
    end else begin
      checks++;
      $display("FAIL %s: got timeout expected req %h", n, exp);
    end
  endtask

  initial begin
    vec_t vt[4];
    int   n0;
    bit   any;
    bit   got;

    vt[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 1'b0};
    vt[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vt[2] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104, 1'b1};
    vt[3] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 1'b1};

    // reset state
    step(3);
    q.delete();
    chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h0);
`ifdef FETCH_ALIGN_CHK_EN
    chk("rst_align", {31'h0, align_err}, 32'h0);
`endif
    reset = 1'b1;
    mem_kill = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("req_pre", {31'h0, bus.imem_req}, 32'h0);
    @(negedge clk);
    chk("first_req", {31'h0, bus.imem_req}, 32'h1);
    chk("first_addr", bus.imem_addr, 32'h0);
    expect_req("seq_4", 32'h4);
    expect_req("seq_8", 32'h8);
    expect_req("seq_c", 32'hC);

    // stall until the buffer is full
    step(1);
    stall = 1'b1;
    step(12);
    n0 = nreq;
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.imem_req) any = 1'b1;
    end
    chk("stall_req", {31'h0, any}, 32'h0);
    chk("stall_nreq", nreq, n0);
    chk("fifo_fill", q.size(), 32'd2);
    chk("stall_valid", {31'h0, instr_valid}, 32'h1);
    step(1);
    stall = 1'b0;
    step(12);

    // redirect while a 3-cycle read of 0x8 is in flight
    do_reset(2);
    mem_lat = 3;
    expect_req("br_a0", 32'h0);
    expect_req("br_a4", 32'h4);
    expect_req("br_a8", 32'h8);
    step(1);
    do_branch(32'h100);
    any = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.imem_req;
      if (instr_valid) any = 1'b1;
    end
    chk("br_empty", {31'h0, any}, 32'h0);
    chk("br_addr", got ? bus.imem_addr : 32'hFFFF_FFFF,
        32'h100);
    any = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = instr_valid;
    end
    chk("br_word", got ? instr : 32'hFFFF_FFFF, word(32'h100));
    step(6);

    // redirect coinciding with return data and a stall
    mem_lat = 1;
    step(1);
    stall = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.imem_req && instr_valid;
    end
    chk("bv_setup", {31'h0, got}, 32'h1);
    step(1);
    do_branch(32'h200);
    @(negedge clk);
    chk("bv_valid", {31'h0, instr_valid}, 32'h0);
    chk("bv_instr", instr, 32'h0);
    expect_req("bv_addr", 32'h200);
    step(1);
    stall = 1'b0;
    step(8);

    // reset mid-WAIT followed by a stale return
    mem_lat = 3;
    do_reset(2);
    expect_req("st_a0", 32'h0);
    expect_req("st_a4", 32'h4);
    step(1);
    reset = 1'b0;
    mem_kill = 1'b1;
    inj_cyc = cyc + 1;
    step(1);
    q.delete();
    reset = 1'b1;
    mem_kill = 1'b0;
    @(negedge clk);
    chk("st_rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("st_rst_valid", {31'h0, instr_valid}, 32'h0);
    expect_req("st_restart", 32'h0);
    step(12);

    // redirect targets: alignment and pc wrap
    mem_lat = 1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      do_branch(vt[k].target);
      expect_req($sformatf("tgt%0d_a0", k), vt[k].a0);
      expect_req($sformatf("tgt%0d_a1", k), vt[k].a1);
`ifdef FETCH_ALIGN_CHK_EN
      chk($sformatf("tgt%0d_err", k), {31'h0, align_err},
          {31'h0, vt[k].err});
`endif
    end
    step(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
